// File: rtl/mc_ctrl_pkg.sv
// rtl/mc_ctrl_pkg.sv - shared state, opcode, ALU-code and instruction-field definitions
// for mc_control_fsm and the ALU it drives.
package mc_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_FETCH  = 3'd0,
      ST_DECODE = 3'd1,
      ST_EXEC   = 3'd2,
      ST_MEM    = 3'd3,
      ST_WB     = 3'd4,
      ST_TRAP   = 3'd5
   } state_t;

   localparam logic [5:0] OP_NOP  = 6'h00;
   localparam logic [5:0] OP_ADD  = 6'h01;
   localparam logic [5:0] OP_SUB  = 6'h02;
   localparam logic [5:0] OP_AND  = 6'h03;
   localparam logic [5:0] OP_OR   = 6'h04;
   localparam logic [5:0] OP_MUL  = 6'h05;
   localparam logic [5:0] OP_ADDI = 6'h10;
   localparam logic [5:0] OP_LW   = 6'h11;
   localparam logic [5:0] OP_SW   = 6'h12;

   // Encodings consumed by the ALU; keep in step with its operation decode.
   localparam logic [3:0] ALU_NONE = 4'b0000;
   localparam logic [3:0] ALU_ADD  = 4'b0001;
   localparam logic [3:0] ALU_SUB  = 4'b0010;
   localparam logic [3:0] ALU_AND  = 4'b0011;
   localparam logic [3:0] ALU_OR   = 4'b0100;
   localparam logic [3:0] ALU_MUL  = 4'b0101;

   localparam int OPC_LSB = 26;
   localparam int RD_LSB  = 21;
   localparam int RS1_LSB = 16;
   localparam int RS2_LSB = 11;
   localparam int IMM_LSB = 0;

   function automatic logic [31:0] sext16(input logic [15:0] v);
      return {{16{v[15]}}, v};
   endfunction

endpackage

// File: rtl/mc_decoder.sv
// rtl/mc_decoder.sv - combinational instruction decode from the IR; MUL decodes only
// when MC_CTRL_MUL_EN is defined, otherwise opcode 0x05 is illegal.
module mc_decoder
   import mc_ctrl_pkg::*;
(
   input  logic [31:0] ir,
   output logic [3:0]  alu_ctrl,
   output logic        alu_src_imm,
   output logic        is_load,
   output logic        is_store,
   output logic        is_mul,
   output logic        is_nop,
   output logic        is_illegal,
   output logic [31:0] imm,
   output logic [4:0]  rd_addr,
   output logic [4:0]  rs1_addr,
   output logic [4:0]  rs2_addr
);

   logic [5:0] opcode;

   assign opcode   = ir[OPC_LSB +: 6];
   assign rd_addr  = ir[RD_LSB +: 5];
   assign rs1_addr = ir[RS1_LSB +: 5];
   assign rs2_addr = ir[RS2_LSB +: 5];
   assign imm      = sext16(ir[IMM_LSB +: 16]);

   always_comb begin
      alu_ctrl    = ALU_NONE;
      alu_src_imm = 1'b0;
      is_load     = 1'b0;
      is_store    = 1'b0;
      is_mul      = 1'b0;
      is_nop      = 1'b0;
      is_illegal  = 1'b0;
      case (opcode)
         OP_NOP: is_nop   = 1'b1;
         OP_ADD: alu_ctrl = ALU_ADD;
         OP_SUB: alu_ctrl = ALU_SUB;
         OP_AND: alu_ctrl = ALU_AND;
         OP_OR:  alu_ctrl = ALU_OR;
`ifdef MC_CTRL_MUL_EN
         OP_MUL: begin
            alu_ctrl = ALU_MUL;
            is_mul   = 1'b1;
         end
`endif
         // Immediate and memory ops all compute rs1 + imm.
         OP_ADDI: begin
            alu_ctrl    = ALU_ADD;
            alu_src_imm = 1'b1;
         end
         OP_LW: begin
            alu_ctrl    = ALU_ADD;
            alu_src_imm = 1'b1;
            is_load     = 1'b1;
         end
         OP_SW: begin
            alu_ctrl    = ALU_ADD;
            alu_src_imm = 1'b1;
            is_store    = 1'b1;
         end
         default: is_illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/mc_control_fsm.sv
// rtl/mc_control_fsm.sv - multi-cycle fetch/decode/exec/mem/wb control unit; the
// MUL_LATENCY-cycle MUL path exists only when MC_CTRL_MUL_EN is defined.
module mc_control_fsm
   import mc_ctrl_pkg::*;
#(
   parameter int MUL_LATENCY = 3
)
(
   input  logic        clk,
   input  logic        reset_n,
   output logic        imem_req,
   input  logic        imem_ready,
   input  logic [31:0] instr,
   output logic        pc_we,
   output logic [3:0]  alu_ctrl,
   output logic        alu_src_imm,
   output logic        aluout_we,
   output logic [4:0]  rs1_addr,
   output logic [4:0]  rs2_addr,
   output logic [4:0]  rd_addr,
   output logic [31:0] imm,
   output logic        dmem_req,
   output logic        dmem_we,
   input  logic        dmem_ready,
   output logic        wb_sel,
   output logic        reg_we,
   output logic        illegal,
   output logic [2:0]  state
);

   if (MUL_LATENCY < 1 || MUL_LATENCY > 15) begin : g_bad_mul_latency
      $error("mc_control_fsm: MUL_LATENCY must be 1..15");
   end

   state_t      state_q, state_d;
   logic [31:0] ir_q;

   logic [3:0]  dec_alu_ctrl;
   logic        dec_alu_src_imm;
   logic        dec_is_load, dec_is_store, dec_is_mul, dec_is_nop, dec_is_illegal;
   logic        mul_done, exec_last;

   mc_decoder u_decoder (
      .ir          (ir_q),
      .alu_ctrl    (dec_alu_ctrl),
      .alu_src_imm (dec_alu_src_imm),
      .is_load     (dec_is_load),
      .is_store    (dec_is_store),
      .is_mul      (dec_is_mul),
      .is_nop      (dec_is_nop),
      .is_illegal  (dec_is_illegal),
      .imm         (imm),
      .rd_addr     (rd_addr),
      .rs1_addr    (rs1_addr),
      .rs2_addr    (rs2_addr)
   );

`ifdef MC_CTRL_MUL_EN
   // Loaded with LATENCY-1 so that a zero count marks the final EXEC cycle.
   logic [3:0] mul_cnt_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mul_cnt_q <= 4'd0;
      end else if (state_q == ST_DECODE) begin
         mul_cnt_q <= 4'(MUL_LATENCY - 1);
      end else if (state_q == ST_EXEC && mul_cnt_q != 4'd0) begin
         mul_cnt_q <= mul_cnt_q - 4'd1;
      end
   end

   assign mul_done = (mul_cnt_q == 4'd0);
`else
   assign mul_done = 1'b1;
`endif

   assign exec_last = !dec_is_mul || mul_done;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_FETCH;
         ir_q    <= 32'd0;
      end else begin
         state_q <= state_d;
         if (state_q == ST_FETCH && imem_ready) begin
            ir_q <= instr;
         end
      end
   end

   // FETCH outputs are gated by reset_n so the bus stays quiet while reset is held.
   always_comb begin
      state_d     = state_q;
      imem_req    = 1'b0;
      pc_we       = 1'b0;
      alu_ctrl    = ALU_NONE;
      alu_src_imm = 1'b0;
      aluout_we   = 1'b0;
      dmem_req    = 1'b0;
      dmem_we     = 1'b0;
      wb_sel      = 1'b0;
      reg_we      = 1'b0;
      illegal     = 1'b0;
      case (state_q)
         ST_FETCH: begin
            imem_req = reset_n;
            if (imem_ready) begin
               pc_we   = reset_n;
               state_d = ST_DECODE;
            end
         end
         ST_DECODE: begin
            if (dec_is_nop) begin
               state_d = ST_FETCH;
            end else if (dec_is_illegal) begin
               state_d = ST_TRAP;
            end else begin
               state_d = ST_EXEC;
            end
         end
         ST_EXEC: begin
            alu_ctrl    = dec_alu_ctrl;
            alu_src_imm = dec_alu_src_imm;
            if (exec_last) begin
               aluout_we = 1'b1;
               state_d   = (dec_is_load || dec_is_store) ? ST_MEM : ST_WB;
            end
         end
         ST_MEM: begin
            dmem_req = 1'b1;
            dmem_we  = dec_is_store;
            if (dmem_ready) begin
               state_d = dec_is_load ? ST_WB : ST_FETCH;
            end
         end
         ST_WB: begin
            reg_we  = 1'b1;
            wb_sel  = dec_is_load;
            state_d = ST_FETCH;
         end
         ST_TRAP: begin
            illegal = 1'b1;
         end
         default: begin
            state_d = ST_FETCH;
         end
      endcase
   end

   assign state = state_q;

endmodule

// File: doc/mc_control_fsm.md
# mc_control_fsm

Multi-cycle control unit for the core: fetches one instruction at a time over a ready/request handshake, decodes it, and sequences the execute, memory and writeback steps. It sits directly upstream of the ALU and drives its 4-bit `alu_ctrl` operation code. It also drives register-file, data-memory and PC enables. One instruction is in flight at a time; there is no pipelining.

## Interface
- `MUL_LATENCY`, 3: EXEC cycles for MUL, range 1..15.
- `clk` in 1: sole clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `imem_req` out 1: instruction fetch request.
- `imem_ready` in 1: fetch complete; `instr` valid this cycle.
- `instr` in 32: instruction word.
- `pc_we` out 1: PC increment pulse.
- `alu_ctrl` out 4: ADD 0001, SUB 0010, AND 0011, OR 0100, MUL 0101, none 0000.
- `alu_src_imm` out 1: ALU B operand is `imm`.
- `aluout_we` out 1: capture ALU result.
- `rs1_addr`, `rs2_addr`, `rd_addr` out 5: register indices.
- `imm` out 32: sign-extended `instr[15:0]`.
- `dmem_req` out 1: data memory request.
- `dmem_we` out 1: store qualifier.
- `dmem_ready` in 1: data access complete.
- `wb_sel` out 1: writeback source, 0 = ALU, 1 = memory.
- `reg_we` out 1: register-file write pulse.
- `illegal` out 1: sticky illegal-opcode flag.
- `state` out 3: current state, for debug.

## Operation
- Instruction format:
  - opcode `[31:26]`, rd `[25:21]`, rs1 `[20:16]`, rs2 `[15:11]`, imm `[15:0]`.
- Opcodes:
  - NOP 0x00.
  - ADD 0x01, SUB 0x02, AND 0x03, OR 0x04, MUL 0x05.
  - ADDI 0x10, LW 0x11, SW 0x12.
  - All other opcodes are illegal.
- An internal IR captures `instr` on the `imem_ready` cycle in FETCH. All decoded outputs derive from the IR.
- States and transitions:
  - FETCH (0): `imem_req`=1 until `imem_ready`. On ready: load IR, pulse `pc_we`, go to DECODE.
  - DECODE (1): NOP goes to FETCH. An illegal opcode goes to TRAP. Everything else goes to EXEC.
  - EXEC (2): `alu_ctrl` valid. ADDI, LW and SW force ADD with `alu_src_imm`=1. `aluout_we` pulses on the last EXEC cycle: cycle 1 for normal ops, cycle `MUL_LATENCY` for MUL. Then LW and SW go to MEM; all others go to WB.
  - MEM (3): `dmem_req`=1 until `dmem_ready`; `dmem_we`=1 for SW. On ready, LW goes to WB and SW goes to FETCH.
  - WB (4): `reg_we`=1 for one cycle; `wb_sel`=1 for LW. Then go to FETCH.
  - TRAP (5): `illegal`=1. All request and enable outputs are 0. Held until reset.
- `alu_ctrl` is 0000 outside EXEC.
- Writes with rd=0 are still issued; the register file ignores them.
- `imem_ready` outside FETCH and `dmem_ready` outside MEM are ignored.

## Timing
- Reset (asynchronous, active-low):
  - state = FETCH; IR = 0.
  - All outputs 0, except `imem_req`=1 once reset deasserts.
  - `illegal` is cleared.
- Reset mid-operation aborts the instruction immediately. No partial `reg_we` or `dmem_req` is emitted afterwards.
- Cycles per instruction with zero-wait memory (`imem_ready`/`dmem_ready` high on the first request cycle):
  - NOP: 2.
  - ALU ops and ADDI: 4.
  - MUL: 3 + `MUL_LATENCY`.
  - SW: 4.
  - LW: 5.
- Each wait cycle on `imem_ready` or `dmem_ready` adds 1 cycle.
- Request signals stay stable while waiting. The IR does not change outside FETCH.
- `pc_we`, `aluout_we` and `reg_we` are exactly one-cycle pulses per instruction.

## Configuration
- `MC_CTRL_MUL_EN` defined:
  - MUL decodes normally.
  - EXEC holds for `MUL_LATENCY` cycles, counted by a 4-bit down-counter loaded in DECODE.
- `MC_CTRL_MUL_EN` undefined:
  - Opcode 0x05 is illegal and goes to TRAP.
  - The counter logic is absent.
  - `alu_ctrl` never takes 0101.

## Structure
- Package `mc_ctrl_pkg` holds:
  - state enum;
  - opcode constants;
  - `alu_ctrl` encodings, shared with the ALU;
  - instruction field bit positions.
- Sub-module `mc_decoder` (combinational) maps IR to:
  - `alu_ctrl`, `alu_src_imm`;
  - is_load, is_store, is_mul, is_nop, is_illegal;
  - `imm`.
- The FSM, IR and MUL counter live in the top level.

## Test plan
- ADD `0x04221800`, zero-wait:
  - FETCH→DECODE→EXEC→WB across 4 cycles.
  - `alu_ctrl`=0001 in EXEC.
  - `reg_we`=1 with `rd_addr`=1, `rs1_addr`=2, `rs2_addr`=3.
- LW `0x44A00004` with `dmem_ready` delayed 2 cycles:
  - `imm`=4, `alu_src_imm`=1.
  - `dmem_req` held 3 cycles, `dmem_we`=0.
  - `wb_sel`=1, `reg_we` for rd=5.
  - Total 7 cycles.
- MUL `0x14221800`, `MUL_LATENCY`=3, macro defined:
  - `alu_ctrl`=0101 for 3 cycles; `aluout_we` on the third.
  - 6 cycles total.
  - With the macro undefined: `illegal`=1, state TRAP.
- Illegal `0xFC000000`:
  - TRAP after DECODE.
  - `illegal` stays 1 and `imem_req` stays 0 for 20 cycles.
  - A `reset_n` pulse clears both.
- `reset_n` low during MEM of SW:
  - All outputs 0 asynchronously.
  - After release, state=FETCH and `imem_req`=1.
  - No `dmem_req` is issued for the aborted SW.
